// File: rtl/char_buf_pkg.sv
// -----------------------------------------------------------------------------
// char_buf_pkg
// Shared definitions for the 70x30 text-mode character buffer. Both the
// writer and the VGA text reader use these so that geometry, fill code and
// address packing agree on both ports of the char buffer.
//   CB_COLS / CB_ROWS  : screen geometry
//   CB_BLANK           : fill code for sweeps and backspace
//   ASCII_*            : control codes interpreted by the writer
//   state_t / ST_*     : writer FSM encoding
//   char_addr_pack()   : {3'b000, h[6:0], v[4:0]} buffer address
// -----------------------------------------------------------------------------
package char_buf_pkg;

   localparam int         CB_COLS  = 70;
   localparam int         CB_ROWS  = 30;
   localparam logic [7:0] CB_BLANK = 8'h20;

   localparam logic [7:0] ASCII_BS       = 8'h08;
   localparam logic [7:0] ASCII_LF       = 8'h0A;
   localparam logic [7:0] ASCII_FF       = 8'h0C;
   localparam logic [7:0] ASCII_CR       = 8'h0D;
   localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
   localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE     = 2'd0;
   localparam state_t ST_WRITE    = 2'd1;
   localparam state_t ST_CLR_LINE = 2'd2;
   localparam state_t ST_CLR_ALL  = 2'd3;

   function automatic logic [14:0] char_addr_pack(input logic [6:0] h,
                                                  input logic [4:0] v);
      return {3'b000, h, v};
   endfunction

endpackage

// File: rtl/char_buf_sweep.sv
// -----------------------------------------------------------------------------
// char_buf_sweep
// Cell counter for blank sweeps. One cell is presented per cycle, h ascending
// (inner), v ascending (outer, full-screen mode only).
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   start_i        : begin a sweep; the first cell is presented this cycle
//   mode_all_i     : 1 = whole screen from row 0, 0 = single row row_i
//   row_i          : row to sweep in line mode
//   cell_h_o/v_o   : cell to write this cycle (valid when cell_vld_o)
//   cell_vld_o     : a sweep cell is presented this cycle
//   busy_o         : sweep in progress (registered)
//   done_o         : the presented cell is the final one
// -----------------------------------------------------------------------------
module char_buf_sweep
   import char_buf_pkg::*;
#(
   parameter int COLS = CB_COLS,
   parameter int ROWS = CB_ROWS
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       start_i,
   input  logic       mode_all_i,
   input  logic [4:0] row_i,
   output logic [6:0] cell_h_o,
   output logic [4:0] cell_v_o,
   output logic       cell_vld_o,
   output logic       busy_o,
   output logic       done_o
);

   localparam logic [6:0] H_LAST = 7'(COLS - 1);
   localparam logic [4:0] V_LAST = 5'(ROWS - 1);

   logic [6:0] cnt_h_q, cnt_h_d;
   logic [4:0] cnt_v_q, cnt_v_d;
   logic       busy_q, busy_d;
   logic       mode_all_q, mode_all_d;
   logic       mode_all_cur;
   logic       last_col;
   logic       last_cell;

   // On start the first cell bypasses the counter so the first blank write
   // can be registered in the same cycle the sweep is requested.
   always_comb begin
      cell_vld_o   = start_i | busy_q;
      cell_h_o     = start_i ? 7'd0 : cnt_h_q;
      cell_v_o     = start_i ? (mode_all_i ? 5'd0 : row_i) : cnt_v_q;
      mode_all_cur = start_i ? mode_all_i : mode_all_q;
      last_col     = (cell_h_o == H_LAST);
      last_cell    = last_col && (!mode_all_cur || (cell_v_o == V_LAST));
      done_o       = cell_vld_o && last_cell;

      cnt_h_d    = cnt_h_q;
      cnt_v_d    = cnt_v_q;
      busy_d     = busy_q;
      mode_all_d = mode_all_cur;
      if (cell_vld_o) begin
         if (last_cell) begin
            busy_d = 1'b0;
         end else begin
            busy_d = 1'b1;
            if (last_col) begin
               cnt_h_d = 7'd0;
               cnt_v_d = cell_v_o + 5'd1;
            end else begin
               cnt_h_d = cell_h_o + 7'd1;
               cnt_v_d = cell_v_o;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_h_q    <= 7'd0;
         cnt_v_q    <= 5'd0;
         busy_q     <= 1'b0;
         mode_all_q <= 1'b0;
      end else begin
         cnt_h_q    <= cnt_h_d;
         cnt_v_q    <= cnt_v_d;
         busy_q     <= busy_d;
         mode_all_q <= mode_all_d;
      end
   end

   assign busy_o = busy_q;

endmodule

// File: rtl/char_buf_writer.sv
// -----------------------------------------------------------------------------
// char_buf_writer
// Write-side terminal engine for the 70x30 character buffer. Accepts ASCII
// bytes, keeps a cursor, writes printable characters, interprets LF/CR/BS/FF
// and runs blank sweeps through char_buf_sweep.
//   clk_50m, rst_n         : clock, asynchronous active-low reset
//   key_ascii, key_valid   : byte from the source
//   key_ready              : byte is taken on an edge with key_valid && key_ready
//   char_wr_en/addr/data   : registered write port to the char buffer
//   h_cur, v_cur           : cursor position (registered)
//   dbg_state              : current FSM state (ST_* in char_buf_pkg)
// Build option CHAR_BUF_LINE_CLEAR_EN: when defined, line wrap and LF sweep
// the new row to BLANK; when undefined they only move the cursor.
//
// Handshake: valid/ready. The source holds key_ascii stable with key_valid
// high until an edge on which key_ready is also high; that edge transfers the
// byte. key_ready is high only in IDLE and is low for at least one cycle
// after every transfer.
// -----------------------------------------------------------------------------
module char_buf_writer
   import char_buf_pkg::*;
#(
   parameter int         COLS  = CB_COLS,
   parameter int         ROWS  = CB_ROWS,
   parameter logic [7:0] BLANK = CB_BLANK
) (
   input  logic        clk_50m,
   input  logic        rst_n,
   input  logic [7:0]  key_ascii,
   input  logic        key_valid,
   output logic        key_ready,
   output logic        char_wr_en,
   output logic [14:0] char_wr_addr,
   output logic [7:0]  char_wr_data,
   output logic [6:0]  h_cur,
   output logic [4:0]  v_cur,
   output logic [1:0]  dbg_state
);

   localparam logic [6:0] H_LAST = 7'(COLS - 1);
   localparam logic [4:0] V_LAST = 5'(ROWS - 1);

   state_t      state_q, state_d;
   logic        key_ready_q, key_ready_d;
   logic        wr_en_q, wr_en_d;
   logic [14:0] wr_addr_q, wr_addr_d;
   logic [7:0]  wr_data_q, wr_data_d;
   logic [6:0]  h_q, h_d;
   logic [4:0]  v_q, v_d;

   logic        accept;
   logic        is_print;
   logic [4:0]  next_row;

   logic        sweep_start;
   logic        sweep_mode_all;
   logic [4:0]  sweep_row;
   logic [6:0]  sweep_h;
   logic [4:0]  sweep_v;
   logic        sweep_vld;
   logic        sweep_busy;
   logic        sweep_done;

   char_buf_sweep #(
      .COLS (COLS),
      .ROWS (ROWS)
   ) u_sweep (
      .clk_i      (clk_50m),
      .rst_n_i    (rst_n),
      .start_i    (sweep_start),
      .mode_all_i (sweep_mode_all),
      .row_i      (sweep_row),
      .cell_h_o   (sweep_h),
      .cell_v_o   (sweep_v),
      .cell_vld_o (sweep_vld),
      .busy_o     (sweep_busy),
      .done_o     (sweep_done)
   );

   assign accept   = key_valid && key_ready_q;
   assign is_print = (key_ascii >= ASCII_PRINT_LO) && (key_ascii <= ASCII_PRINT_HI);
   // No scrolling: the row index wraps.
   assign next_row = (v_q == V_LAST) ? 5'd0 : v_q + 5'd1;

   always_comb begin
      state_d        = state_q;
      h_d            = h_q;
      v_d            = v_q;
      wr_en_d        = 1'b0;
      wr_addr_d      = wr_addr_q;
      wr_data_d      = wr_data_q;
      sweep_start    = 1'b0;
      sweep_mode_all = 1'b0;
      sweep_row      = v_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               // WRITE is the single cycle with key_ready low before IDLE.
               state_d = ST_WRITE;
               if (is_print) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = char_addr_pack(h_q, v_q);
                  wr_data_d = key_ascii;
                  if (h_q == H_LAST) begin
                     h_d = 7'd0;
                     v_d = next_row;
`ifdef CHAR_BUF_LINE_CLEAR_EN
                     // Sweep starts next cycle, after the character write.
                     state_d = ST_CLR_LINE;
`endif
                  end else begin
                     h_d = h_q + 7'd1;
                  end
               end else if (key_ascii == ASCII_LF) begin
                  h_d = 7'd0;
                  v_d = next_row;
`ifdef CHAR_BUF_LINE_CLEAR_EN
                  sweep_start = 1'b1;
                  sweep_row   = next_row;
                  state_d     = ST_CLR_LINE;
`endif
               end else if (key_ascii == ASCII_CR) begin
                  h_d = 7'd0;
               end else if (key_ascii == ASCII_BS) begin
                  if (h_q != 7'd0) begin
                     h_d       = h_q - 7'd1;
                     wr_en_d   = 1'b1;
                     wr_addr_d = char_addr_pack(h_q - 7'd1, v_q);
                     wr_data_d = BLANK;
                  end
               end else if (key_ascii == ASCII_FF) begin
                  h_d            = 7'd0;
                  v_d            = 5'd0;
                  sweep_start    = 1'b1;
                  sweep_mode_all = 1'b1;
                  state_d        = ST_CLR_ALL;
               end
            end
         end
`ifdef CHAR_BUF_LINE_CLEAR_EN
         ST_CLR_LINE: begin
            // Entered idle from a wrap: kick the sweep on the new row.
            if (!sweep_busy) begin
               sweep_start = 1'b1;
            end
            if (sweep_done) begin
               state_d = ST_WRITE;
            end
         end
`endif
         ST_CLR_ALL: begin
            if (sweep_done || !sweep_busy) begin
               state_d = ST_WRITE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (sweep_vld) begin
         wr_en_d   = 1'b1;
         wr_addr_d = char_addr_pack(sweep_h, sweep_v);
         wr_data_d = BLANK;
      end

      key_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         key_ready_q <= 1'b1;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= 15'd0;
         wr_data_q   <= 8'h00;
         h_q         <= 7'd0;
         v_q         <= 5'd0;
      end else begin
         state_q     <= state_d;
         key_ready_q <= key_ready_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         h_q         <= h_d;
         v_q         <= v_d;
      end
   end

   assign key_ready    = key_ready_q;
   assign char_wr_en   = wr_en_q;
   assign char_wr_addr = wr_addr_q;
   assign char_wr_data = wr_data_q;
   assign h_cur        = h_q;
   assign v_cur        = v_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_char_buf_writer.sv
// -----------------------------------------------------------------------------
// tb_char_buf_writer
// Randomized scoreboard bench for char_buf_writer. A behavioural terminal
// model turns every accepted byte into a list of expected writes (cycle,
// address, data) and an expected busy length plus final cursor. Two monitors
// pop and compare: one on every char_wr_en cycle, one whenever key_ready
// returns high.
// -----------------------------------------------------------------------------
module tb_char_buf_writer;

   localparam int COLS = 70;
   localparam int ROWS = 30;

   // clock / reset
   logic        clk_50m = 1'b0;
   logic        rst_n;
   logic [7:0]  key_ascii;
   logic        key_valid;
   logic        key_ready;
   logic        char_wr_en;
   logic [14:0] char_wr_addr;
   logic [7:0]  char_wr_data;
   logic [6:0]  h_cur;
   logic [4:0]  v_cur;
   logic [1:0]  dbg_state;

   always #10 clk_50m = ~clk_50m;

   int cyc = 0;
   always @(posedge clk_50m) cyc <= cyc + 1;

   char_buf_writer dut (
      .clk_50m      (clk_50m),
      .rst_n        (rst_n),
      .key_ascii    (key_ascii),
      .key_valid    (key_valid),
      .key_ready    (key_ready),
      .char_wr_en   (char_wr_en),
      .char_wr_addr (char_wr_addr),
      .char_wr_data (char_wr_data),
      .h_cur        (h_cur),
      .v_cur        (v_cur),
      .dbg_state    (dbg_state)
   );

   // scoreboard state
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [54:0] exp_q[$];   // {cycle[31:0], addr[14:0], data[7:0]}
   logic [27:0] busy_q[$];  // {ready_low_cycles[15:0], h[6:0], v[4:0]}
   int          m_h, m_v;
   int          wr_cnt;
   bit          rdy_mon_en;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
      end
   endtask

   task automatic push_wr(input int at, input int h, input int v, input logic [7:0] d);
      exp_q.push_back({32'(at), 3'b000, 7'(h), 5'(v), d});
   endtask

   // Terminal model. acc = cycle count seen at the sample point just after
   // the accepting edge; a write "in cycle N+k" is seen at acc + k - 1.
   task automatic model_byte(input logic [7:0] c, input int acc);
      int len;
      len = 1;
      if (c >= 8'h20 && c <= 8'h7E) begin
         push_wr(acc, m_h, m_v, c);
         if (m_h == COLS - 1) begin
            m_h = 0;
            m_v = (m_v + 1) % ROWS;
`ifdef CHAR_BUF_LINE_CLEAR_EN
            for (int i = 0; i < COLS; i++) push_wr(acc + 1 + i, i, m_v, 8'h20);
            len = COLS + 1;
`endif
         end else begin
            m_h = m_h + 1;
         end
      end else if (c == 8'h0A) begin
         m_h = 0;
         m_v = (m_v + 1) % ROWS;
`ifdef CHAR_BUF_LINE_CLEAR_EN
         for (int i = 0; i < COLS; i++) push_wr(acc + i, i, m_v, 8'h20);
         len = COLS;
`endif
      end else if (c == 8'h0D) begin
         m_h = 0;
      end else if (c == 8'h08) begin
         if (m_h > 0) begin
            m_h = m_h - 1;
            push_wr(acc, m_h, m_v, 8'h20);
         end
      end else if (c == 8'h0C) begin
         m_h = 0;
         m_v = 0;
         for (int v = 0; v < ROWS; v++)
            for (int h = 0; h < COLS; h++)
               push_wr(acc + v * COLS + h, h, v, 8'h20);
         len = ROWS * COLS;
      end
      busy_q.push_back({16'(len), 7'(m_h), 5'(m_v)});
   endtask

   // monitors
   task automatic wr_monitor();
      logic [54:0] e;
      forever begin
         @(negedge clk_50m);
         if (char_wr_en === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL wr_unexpected: write addr 0x%0h data 0x%0h at cycle %0d, none expected",
                        char_wr_addr, char_wr_data, cyc);
            end else begin
               e = exp_q.pop_front();
               n_checks++;
               if ({32'(cyc), char_wr_addr, char_wr_data} !== e) begin
                  n_fail++;
                  $display("FAIL wr_entry: got cyc %0d addr 0x%0h data 0x%0h, expected cyc %0d addr 0x%0h data 0x%0h",
                           cyc, char_wr_addr, char_wr_data, e[54:23], e[22:8], e[7:0]);
               end
            end
         end
      end
   endtask

   task automatic rdy_monitor();
      int          run;
      logic [27:0] e;
      run = 0;
      forever begin
         @(negedge clk_50m);
         if (!rdy_mon_en) begin
            run = 0;
         end else if (key_ready !== 1'b1) begin
            run++;
         end else if (run > 0) begin
            if (busy_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL busy_unexpected: key_ready low for %0d cycles, no transfer expected", run);
            end else begin
               e = busy_q.pop_front();
               chk("ready_low_cycles", 64'(run), 64'(e[27:12]));
               chk("cursor_h", 64'(h_cur), 64'(e[11:5]));
               chk("cursor_v", 64'(v_cur), 64'(e[4:0]));
            end
            run = 0;
         end
      end
   endtask

   // driver tasks
   // Leaves key_valid high after the transfer; send() again to stream bytes
   // back to back, or idle() to drop valid.
   task automatic send(input logic [7:0] c);
      int g;
      g = 0;
      @(negedge clk_50m);
      while (key_ready !== 1'b1 && g < 5000) begin
         @(negedge clk_50m);
         g++;
      end
      chk("send_ready", 64'(key_ready), 64'd1);
      key_ascii = c;
      key_valid = 1'b1;
      model_byte(c, cyc + 1);
      @(posedge clk_50m);
   endtask

   task automatic idle();
      @(negedge clk_50m);
      key_valid = 1'b0;
   endtask

   task automatic send_one(input logic [7:0] c);
      send(c);
      idle();
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((exp_q.size() != 0 || busy_q.size() != 0) && g < 5000) begin
         @(negedge clk_50m);
         g++;
      end
      chk("drain_exp_q", 64'(exp_q.size()), 64'd0);
      chk("drain_busy_q", 64'(busy_q.size()), 64'd0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_key_ready"}, 64'(key_ready), 64'd1);
      chk({tag, "_wr_en"}, 64'(char_wr_en), 64'd0);
      chk({tag, "_wr_addr"}, 64'(char_wr_addr), 64'd0);
      chk({tag, "_wr_data"}, 64'(char_wr_data), 64'd0);
      chk({tag, "_h_cur"}, 64'(h_cur), 64'd0);
      chk({tag, "_v_cur"}, 64'(v_cur), 64'd0);
   endtask

   function automatic logic [7:0] rand_byte();
      logic [7:0] b;
      case ($urandom_range(0, 9))
         0, 1, 2, 3, 4, 5: b = 8'($urandom_range(32, 126));
         6:                b = 8'h0A;
         7:                b = 8'h0D;
         8:                b = 8'h08;
         default: begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h0C) b = 8'h07;
         end
      endcase
      return b;
   endfunction

   initial begin
      int base;
      int g;
      rst_n      = 1'b0;
      key_valid  = 1'b0;
      key_ascii  = 8'h00;
      rdy_mon_en = 1'b0;
      m_h        = 0;
      m_v        = 0;
      wr_cnt     = 0;
      fork
         wr_monitor();
         rdy_monitor();
      join_none

      repeat (3) @(negedge clk_50m);
      check_reset_values("reset");
      rst_n      = 1'b1;
      rdy_mon_en = 1'b1;

      // first character at home position
      send_one(8'h41);

      // line wrap from (69,5)
      send_one(8'h0D);
      repeat (5) send_one(8'h0A);
      repeat (69) send_one(8'($urandom_range(32, 126)));
      send_one(8'h5A);

      // LF from the last row wraps to row 0, then CR
      repeat (23) send_one(8'h0A);
      repeat (10) send_one(8'($urandom_range(32, 126)));
      send_one(8'h0A);
      send_one(8'h0D);

      // backspace mid-line and at column 0, then an ignored code
      send_one(8'h0A);
      send_one(8'h0A);
      repeat (3) send_one(8'($urandom_range(32, 126)));
      send_one(8'h08);
      send_one(8'h0D);
      send_one(8'h08);
      send_one(8'h07);

      // random stream, one byte at a time
      for (int i = 0; i < 150; i++) send_one(rand_byte());

      // random stream with key_valid held high through busy periods
      for (int i = 0; i < 120; i++) send(rand_byte());
      idle();

      // full-screen clear
      send_one(8'h0C);
      drain();

      // full-screen clear aborted by reset after 500 writes
      base = wr_cnt;
      send_one(8'h0C);
      g = 0;
      while (wr_cnt < base + 500 && g < 3000) begin
         @(negedge clk_50m);
         g++;
      end
      chk("abort_reached_500_writes", 64'(wr_cnt >= base + 500), 64'd1);
      #1;
      rdy_mon_en = 1'b0;
      rst_n      = 1'b0;
      exp_q.delete();
      busy_q.delete();
      m_h = 0;
      m_v = 0;
      repeat (3) begin
         @(negedge clk_50m);
         chk("abort_no_wr_in_reset", 64'(char_wr_en), 64'd0);
      end
      check_reset_values("abort");
      rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk_50m);
         chk("abort_no_wr_after", 64'(char_wr_en), 64'd0);
      end
      rdy_mon_en = 1'b1;

      // normal operation resumes from home
      send_one(8'h41);
      send_one(8'h0A);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
